read_arbiter_rr: RTL and testbench

Second-generation read-path arbiter for the AXI interconnect. Arbitrates M masters onto the read-address (AR) channel and S slaves onto the read-data (R) channel.
- Keeps a per-(master, transaction-ID) in-order queue of target slaves, DEPTH deep, so each ID can have several transactions outstanding.
- Adds single-cycle eligibility-aware round-robin or fixed priority, decode-error flagging, and beat-qualified R burst termination.

---
 rtl/read_arb_pkg.sv | 38 +++
 rtl/read_arbiter_rr_order_queue.sv | 50 +++++
 rtl/read_arbiter_rr.sv | 181 ++++++++++++++++++
 tb/tb_read_arbiter_rr.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/read_arb_pkg.sv
// Shared types and helpers for the read-path arbiter: FSM encoding,
// arbitration result struct and the round-robin find-first search.
package read_arb_pkg;

  // Upper bound on requesters handled by one search (masters or slaves).
  localparam int MAX_N = 32;
  localparam int IDX_W = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic             vld;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // First set bit of req[0..n-1], scanning ptr, ptr+1, ... mod n.
  // Scanned back-to-front so the earliest position in search order wins.
  function automatic pick_t rr_pick(input logic [MAX_N-1:0] req,
                                    input int n, input int ptr);
    pick_t r;
    int    c;
    r = '0;
    for (int k = MAX_N - 1; k >= 0; k--) begin
      if (k < n) begin
        c = (ptr + k) % n;
        if (req[c]) begin
          r.vld = 1'b1;
          r.idx = IDX_W'(c);
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/read_arbiter_rr_order_queue.sv
// In-order FIFO of target slave indices for one (master, ID) pair.
// Head is the slave allowed to return data next for that ID.
module order_queue #(
  parameter int DATA_WIDTH = 1,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  empty,
  output logic                  full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_q;
  logic [PW-1:0]                    wr_q, rd_q;
  logic [CW-1:0]                    cnt_q;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= din;
  end

  // Pointers and occupancy; push and pop together leave the count unchanged.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= nxt(wr_q);
      if (pop)  rd_q <= nxt(rd_q);
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end

  assign head  = mem_q[rd_q];
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));

endmodule

// File: rtl/read_arbiter_rr.sv
// AXI read-path arbiter: M masters onto AR, S slaves onto R. Each
// (master, ID) keeps an in-order queue of target slaves so R data can
// only be granted to the slave that is next in line for that ID.
module read_arbiter_rr
  import read_arb_pkg::*;
#(
  parameter int         M          = 2,
  parameter int         S          = 2,
  parameter int         ID_W       = 1,
  parameter int         DEPTH      = 4,
  parameter int         ADDR_WIDTH = 32,
  parameter logic [63:0] SLICE_SIZE = 64'h0001_0000,
  parameter int         ARB_MODE   = 0
) (
  input  logic                                     clk,
  input  logic                                     clr,
  input  logic [M-1:0]                             ar_req,
  input  logic [M-1:0][ADDR_WIDTH-1:0]             ar_addr,
  input  logic [M-1:0][ID_W-1:0]                   ar_id,
  output logic [M-1:0]                             ar_grant,
  output logic [M-1:0][$clog2(S)-1:0]              ar_sel,
  output logic [M-1:0]                             ar_decerr,
  input  logic [S-1:0]                             r_req,
  input  logic [S-1:0][$clog2(M)+ID_W-1:0]         r_id,
  input  logic [S-1:0]                             r_hs,
  input  logic [S-1:0]                             r_last,
  output logic [S-1:0]                             r_grant,
  output logic [S-1:0][$clog2(M)-1:0]              r_sel,
  output logic [M-1:0]                             q_full
);

  localparam int SEL_W = $clog2(S);
  localparam int MID_W = $clog2(M);
  localparam int RID_W = MID_W + ID_W;
  localparam int NID   = 1 << ID_W;
  localparam int NQ    = M * NID;
  localparam int QW    = $clog2(NQ);
  localparam logic [ADDR_WIDTH-1:0] SLICE = ADDR_WIDTH'(SLICE_SIZE);

  // Queue array, flattened as index = master*NID + id.
  logic [NQ-1:0]            q_push, q_pop, q_empty, q_full_v;
  logic [NQ-1:0][SEL_W-1:0] q_head;
  logic [SEL_W-1:0]         q_din;

  for (genvar g = 0; g < NQ; g++) begin : g_q
    order_queue #(.DATA_WIDTH(SEL_W), .DEPTH(DEPTH)) u_q (
      .clk   (clk),
      .clr   (clr),
      .push  (q_push[g]),
      .pop   (q_pop[g]),
      .din   (q_din),
      .head  (q_head[g]),
      .empty (q_empty[g]),
      .full  (q_full_v[g])
    );
  end

  // ---------------- AR side ----------------
  logic [M-1:0][ADDR_WIDTH-1:0] slot_idx;
  logic [M-1:0]                 decerr, ar_elig;
  logic [M-1:0][QW-1:0]         ar_qi;
  pick_t                        ar_pick;
  logic [MID_W-1:0]             aw;
  arb_state_e                   ar_state_q;
  logic [MID_W-1:0]             ar_snd_q, ar_ptr_q;
  logic [M-1:0]                 ar_grant_q, ar_decerr_q;

  // Decode each master's address and decide who may compete this cycle.
  always_comb begin
    for (int m = 0; m < M; m++) begin
      slot_idx[m] = ar_addr[m] / SLICE;
      decerr[m]   = slot_idx[m] >= ADDR_WIDTH'(S);
      ar_sel[m]   = decerr[m] ? '0 : slot_idx[m][SEL_W-1:0];
      ar_qi[m]    = QW'(m * NID + int'(ar_id[m]));
      // A decode error never pushes, so a full queue must not block it.
      ar_elig[m]  = ar_req[m] && (decerr[m] || !q_full_v[ar_qi[m]]);
    end
  end

  assign ar_pick = rr_pick(MAX_N'(ar_elig), M, (ARB_MODE != 0) ? 0 : int'(ar_ptr_q));
  assign aw      = MID_W'(ar_pick.idx);

  // Record the target slave for the winner's ID at the moment it is chosen.
  always_comb begin
    q_push = '0;
    q_din  = ar_sel[aw];
    if (ar_state_q == IDLE && ar_pick.vld && !decerr[aw]) q_push[ar_qi[aw]] = 1'b1;
  end

  // AR FSM: pick in IDLE, hold the grant until the winner drops its request.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      ar_state_q  <= IDLE;
      ar_snd_q    <= '0;
      ar_ptr_q    <= '0;
      ar_grant_q  <= '0;
      ar_decerr_q <= '0;
    end else begin
      ar_decerr_q <= '0;
      case (ar_state_q)
        IDLE: if (ar_pick.vld) begin
          ar_snd_q    <= aw;
          ar_grant_q  <= M'(1) << aw;
          ar_decerr_q <= decerr[aw] ? (M'(1) << aw) : '0;
          ar_ptr_q    <= MID_W'((int'(aw) + 1) % M);
          ar_state_q  <= GRANT;
        end
        GRANT: if (!ar_req[ar_snd_q]) begin
          ar_grant_q <= '0;
          ar_state_q <= IDLE;
        end
        default: ar_state_q <= IDLE;
      endcase
    end
  end

  assign ar_grant  = ar_grant_q;
  assign ar_decerr = ar_decerr_q;

  // Any full ID queue of a master is reported for that master.
  always_comb begin
    for (int m = 0; m < M; m++) q_full[m] = |q_full_v[m*NID +: NID];
  end

  // ---------------- R side ----------------
  logic [S-1:0][MID_W-1:0] r_mm;
  logic [S-1:0][QW-1:0]    r_qi;
  logic [S-1:0]            r_elig;
  pick_t                   r_pick;
  logic [SEL_W-1:0]        rw;
  arb_state_e              r_state_q;
  logic [SEL_W-1:0]        r_snd_q, r_ptr_q;
  logic [S-1:0]            r_grant_q;

  // A slave may return data only if it is at the head of its ID's queue.
  always_comb begin
    for (int s = 0; s < S; s++) begin
      r_mm[s]   = r_id[s][RID_W-1:ID_W];
      r_sel[s]  = r_mm[s];
      r_qi[s]   = QW'(int'(r_mm[s]) * NID + int'(r_id[s][ID_W-1:0]));
      r_elig[s] = r_req[s] && (int'(r_mm[s]) < M) && !q_empty[r_qi[s]]
                  && (q_head[r_qi[s]] == SEL_W'(s));
    end
  end

  assign r_pick = rr_pick(MAX_N'(r_elig), S, (ARB_MODE != 0) ? 0 : int'(r_ptr_q));
  assign rw     = SEL_W'(r_pick.idx);

  // The queue entry is consumed when the burst is granted, not when it ends.
  always_comb begin
    q_pop = '0;
    if (r_state_q == IDLE && r_pick.vld) q_pop[r_qi[rw]] = 1'b1;
  end

  // R FSM: pick in IDLE, hold the grant until a handshaked last beat.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state_q <= IDLE;
      r_snd_q   <= '0;
      r_ptr_q   <= '0;
      r_grant_q <= '0;
    end else begin
      case (r_state_q)
        IDLE: if (r_pick.vld) begin
          r_snd_q   <= rw;
          r_grant_q <= S'(1) << rw;
          r_ptr_q   <= SEL_W'((int'(rw) + 1) % S);
          r_state_q <= GRANT;
        end
        GRANT: if (r_hs[r_snd_q] && r_last[r_snd_q]) begin
          r_grant_q <= '0;
          r_state_q <= IDLE;
        end
        default: r_state_q <= IDLE;
      endcase
    end
  end

  assign r_grant = r_grant_q;

endmodule

// File: tb/tb_read_arbiter_rr.sv
// Directed bench: a round-robin and a fixed-priority arbiter share the
// same stimulus; expected grants are worked out cycle by cycle below.
module tb_read_arbiter_rr;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  logic [1:0]       ar_req, r_req, r_hs, r_last;
  logic [1:0][31:0] ar_addr;
  logic [1:0][0:0]  ar_id;
  logic [1:0][1:0]  r_id;
  logic [1:0]       ar_grant, ar_decerr, r_grant, q_full;
  logic [1:0][0:0]  ar_sel, r_sel;
  logic [1:0]       ar_grant_f, ar_decerr_f, r_grant_f, q_full_f;
  logic [1:0][0:0]  ar_sel_f, r_sel_f;

  int vecs = 0;
  int errs = 0;

  read_arbiter_rr #(.ARB_MODE(0)) u_rr (
    .clk(clk), .clr(clr), .ar_req(ar_req), .ar_addr(ar_addr), .ar_id(ar_id),
    .ar_grant(ar_grant), .ar_sel(ar_sel), .ar_decerr(ar_decerr),
    .r_req(r_req), .r_id(r_id), .r_hs(r_hs), .r_last(r_last),
    .r_grant(r_grant), .r_sel(r_sel), .q_full(q_full)
  );

  read_arbiter_rr #(.ARB_MODE(1)) u_fix (
    .clk(clk), .clr(clr), .ar_req(ar_req), .ar_addr(ar_addr), .ar_id(ar_id),
    .ar_grant(ar_grant_f), .ar_sel(ar_sel_f), .ar_decerr(ar_decerr_f),
    .r_req(r_req), .r_id(r_id), .r_hs(r_hs), .r_last(r_last),
    .r_grant(r_grant_f), .r_sel(r_sel_f), .q_full(q_full_f)
  );

  task automatic do_reset;
    clr = 1'b0; ar_req = '0; r_req = '0; r_hs = '0; r_last = '0;
    ar_addr = '0; ar_id = '0; r_id = '0;
    repeat (2) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
  endtask

  // One AR transaction: request, grant expected next cycle, then release.
  task automatic ar_txn(input int m, input logic [31:0] a, input logic id,
                        output logic [1:0] g);
    ar_addr[m] = a; ar_id[m] = id; ar_req[m] = 1'b1;
    @(negedge clk);
    g = ar_grant;
    ar_req[m] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    clr = 1'b0; ar_req = '0; r_req = '0; r_hs = '0; r_last = '0;
    ar_addr = '0; ar_id = '0; r_id = '0;
    @(negedge clk);
    vecs++; if ({ar_grant, r_grant, ar_decerr, q_full} !== 8'h00) begin
      errs++; $display("FAIL rst_rr: got %h want 00", {ar_grant, r_grant, ar_decerr, q_full}); end
    vecs++; if ({ar_grant_f, r_grant_f, ar_decerr_f, q_full_f} !== 8'h00) begin
      errs++; $display("FAIL rst_fix: got %h want 00", {ar_grant_f, r_grant_f, ar_decerr_f, q_full_f}); end
    clr = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_rr;
    do_reset;
    ar_addr[0] = 32'h0001_0000; ar_addr[1] = 32'h0001_0000; ar_req = 2'b11;
    #1;
    vecs++; if (ar_sel !== 2'b11) begin errs++; $display("FAIL rr_sel: got %b want 11", ar_sel); end
    @(negedge clk);
    vecs++; if (ar_grant !== 2'b01) begin errs++; $display("FAIL rr_g0: got %b want 01", ar_grant); end
    ar_req[0] = 1'b0;
    @(negedge clk);
    vecs++; if (ar_grant !== 2'b00) begin errs++; $display("FAIL rr_bubble: got %b want 00", ar_grant); end
    @(negedge clk);
    vecs++; if (ar_grant !== 2'b10) begin errs++; $display("FAIL rr_g1: got %b want 10", ar_grant); end
    ar_req[1] = 1'b0;
    @(negedge clk);
    vecs++; if (ar_grant !== 2'b00) begin errs++; $display("FAIL rr_rel: got %b want 00", ar_grant); end
    // queue[0][0] head is slave 1: slave 0 claiming the same ID must lose
    r_req = 2'b11; r_id[0] = 2'b00; r_id[1] = 2'b00;
    @(negedge clk);
    vecs++; if (r_grant !== 2'b10) begin errs++; $display("FAIL rr_rg_s1: got %b want 10", r_grant); end
    r_hs[1] = 1'b1; r_last[1] = 1'b1; r_req[0] = 1'b0;
    @(negedge clk);
    vecs++; if (r_grant !== 2'b00) begin errs++; $display("FAIL rr_rg_end: got %b want 00", r_grant); end
    r_hs = '0; r_last = '0; r_id[1] = 2'b10;
    @(negedge clk);
    vecs++; if (r_grant !== 2'b10) begin errs++; $display("FAIL rr_rg_m1: got %b want 10", r_grant); end
    vecs++; if (r_sel !== 2'b10) begin errs++; $display("FAIL rr_rsel: got %b want 10", r_sel); end
    r_hs[1] = 1'b1; r_last[1] = 1'b1;
    @(negedge clk);
    r_req = '0; r_hs = '0; r_last = '0;
  endtask

  task automatic test_full;
    logic [1:0] g;
    do_reset;
    for (int i = 0; i < 4; i++) begin
      ar_txn(0, 32'h0, 1'b0, g);
      vecs++; if (g !== 2'b01) begin errs++; $display("FAIL full_fill%0d: got %b want 01", i, g); end
      vecs++; if (q_full !== ((i == 3) ? 2'b01 : 2'b00)) begin
        errs++; $display("FAIL full_flag%0d: got %b want %b", i, q_full, (i == 3) ? 2'b01 : 2'b00); end
    end
    ar_req[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vecs++; if (ar_grant !== 2'b00) begin errs++; $display("FAIL full_block%0d: got %b want 00", i, ar_grant); end
    end
    r_req[0] = 1'b1; r_id[0] = 2'b00;
    @(negedge clk);
    vecs++; if (r_grant !== 2'b01) begin errs++; $display("FAIL full_pop: got %b want 01", r_grant); end
    vecs++; if (ar_grant !== 2'b00) begin errs++; $display("FAIL full_same: got %b want 00", ar_grant); end
    vecs++; if (q_full !== 2'b00) begin errs++; $display("FAIL full_drop: got %b want 00", q_full); end
    @(negedge clk);
    vecs++; if (ar_grant !== 2'b01) begin errs++; $display("FAIL full_g5: got %b want 01", ar_grant); end
    vecs++; if (q_full !== 2'b01) begin errs++; $display("FAIL full_refill: got %b want 01", q_full); end
    ar_req = '0; r_req = '0;
  endtask

  task automatic test_ooo;
    logic [1:0] g;
    do_reset;
    ar_txn(0, 32'h0001_0000, 1'b0, g);
    ar_txn(0, 32'h0000_0000, 1'b0, g);
    r_req[0] = 1'b1; r_id[0] = 2'b00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vecs++; if (r_grant !== 2'b00) begin errs++; $display("FAIL ooo_wait%0d: got %b want 00", i, r_grant); end
    end
    r_req[1] = 1'b1; r_id[1] = 2'b00;
    @(negedge clk);
    vecs++; if (r_grant !== 2'b10) begin errs++; $display("FAIL ooo_s1: got %b want 10", r_grant); end
    r_hs[1] = 1'b1; r_last[1] = 1'b1;
    @(negedge clk);
    vecs++; if (r_grant !== 2'b00) begin errs++; $display("FAIL ooo_end1: got %b want 00", r_grant); end
    r_req[1] = 1'b0; r_hs = '0; r_last = '0;
    @(negedge clk);
    vecs++; if (r_grant !== 2'b01) begin errs++; $display("FAIL ooo_s0: got %b want 01", r_grant); end
    r_hs[0] = 1'b1; r_last[0] = 1'b1;
    @(negedge clk);
    r_req = '0; r_hs = '0; r_last = '0;
  endtask

  task automatic test_burst;
    logic [1:0] g;
    do_reset;
    ar_txn(0, 32'h0, 1'b0, g);
    r_req[0] = 1'b1; r_id[0] = 2'b00;
    @(negedge clk);
    vecs++; if (r_grant !== 2'b01) begin errs++; $display("FAIL bst_start: got %b want 01", r_grant); end
    r_last[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vecs++; if (r_grant !== 2'b01) begin errs++; $display("FAIL bst_hold%0d: got %b want 01", i, r_grant); end
    end
    r_hs[0] = 1'b1;
    @(negedge clk);
    vecs++; if (r_grant !== 2'b00) begin errs++; $display("FAIL bst_end: got %b want 00", r_grant); end
    r_hs = '0; r_last = '0;
    @(negedge clk);
    vecs++; if (r_grant !== 2'b00) begin errs++; $display("FAIL bst_noregrant: got %b want 00", r_grant); end
    r_req = '0;
  endtask

  task automatic test_decerr;
    do_reset;
    ar_addr[0] = 32'h0002_0000; ar_id[0] = 1'b0; ar_req[0] = 1'b1;
    #1;
    vecs++; if (ar_sel !== 2'b00) begin errs++; $display("FAIL dec_sel: got %b want 00", ar_sel); end
    @(negedge clk);
    vecs++; if (ar_grant !== 2'b01) begin errs++; $display("FAIL dec_grant: got %b want 01", ar_grant); end
    vecs++; if (ar_decerr !== 2'b01) begin errs++; $display("FAIL dec_pulse: got %b want 01", ar_decerr); end
    @(negedge clk);
    vecs++; if (ar_decerr !== 2'b00) begin errs++; $display("FAIL dec_once: got %b want 00", ar_decerr); end
    ar_req = '0;
    @(negedge clk);
    r_req = 2'b11; r_id[0] = 2'b00; r_id[1] = 2'b00;
    repeat (2) @(negedge clk);
    vecs++; if (r_grant !== 2'b00) begin errs++; $display("FAIL dec_nopush: got %b want 00", r_grant); end
    r_req = '0;
  endtask

  task automatic test_fixed;
    do_reset;
    ar_req = 2'b11;
    @(negedge clk);
    vecs++; if (ar_grant_f !== 2'b01) begin errs++; $display("FAIL fix_g0: got %b want 01", ar_grant_f); end
    ar_req = 2'b10;
    @(negedge clk);
    ar_req = 2'b11;
    @(negedge clk);
    vecs++; if (ar_grant_f !== 2'b01) begin errs++; $display("FAIL fix_g1: got %b want 01", ar_grant_f); end
    vecs++; if (ar_grant !== 2'b10) begin errs++; $display("FAIL fix_rrcmp: got %b want 10", ar_grant); end
    ar_req = 2'b10;
    @(negedge clk);
    ar_req = 2'b11;
    @(negedge clk);
    vecs++; if (ar_grant_f !== 2'b01) begin errs++; $display("FAIL fix_g2: got %b want 01", ar_grant_f); end
    r_req[0] = 1'b1; r_id[0] = 2'b00;
    @(negedge clk);
    vecs++; if (r_grant_f !== 2'b01) begin errs++; $display("FAIL fix_rg: got %b want 01", r_grant_f); end
    clr = 1'b0;
    #1;
    vecs++; if ({ar_grant_f, r_grant_f, ar_grant, r_grant} !== 8'h00) begin
      errs++; $display("FAIL fix_async_rst: got %h want 00", {ar_grant_f, r_grant_f, ar_grant, r_grant}); end
    ar_req = '0;
    @(negedge clk);
    clr = 1'b1;
    repeat (2) @(negedge clk);
    vecs++; if ({r_grant_f, r_grant, q_full_f} !== 6'h00) begin
      errs++; $display("FAIL fix_q_flushed: got %h want 00", {r_grant_f, r_grant, q_full_f}); end
    r_req = '0;
  endtask

  initial begin
    test_reset;
    test_rr;
    test_full;
    test_ooo;
    test_burst;
    test_decerr;
    test_fixed;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
